// File: rtl/addsub_driver.sv
// Request/response wrapper around the registered addsub unit: drives operands into it,
// shadows the expected result through the unit latency and queues checked results.
module addsub_driver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_add,
    output logic [WIDTH-1:0] drv_dataa,
    output logic [WIDTH-1:0] drv_datab,
    output logic             drv_add_sub,
    input  logic [WIDTH-1:0] unit_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic             err_sticky
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int UW = CW + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready depends only on registered occupancy; rsp_* hold while rsp_valid & !rsp_ready.

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH:0]   w_dif_ext;
    logic [WIDTH:0]   w_exp_ext;
    logic             w_mismatch;
    logic [UW-1:0]    w_used;

    logic [WIDTH-1:0] r_dataa;
    logic [WIDTH-1:0] r_datab;
    logic             r_add_sub;

    logic             r_s1;
    logic [WIDTH-1:0] r_exp1;
    logic             r_carry1;
    logic             r_s2;
    logic [WIDTH-1:0] r_exp2;
    logic             r_carry2;

    logic [WIDTH-1:0] r_mem_data  [DEPTH];
    logic             r_mem_carry [DEPTH];
    logic             r_mem_err   [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_err_sticky;

    // Borrow of A-B is the top bit of the zero-extended difference.
    assign w_sum_ext  = {1'b0, req_a} + {1'b0, req_b};
    assign w_dif_ext  = {1'b0, req_a} - {1'b0, req_b};
    assign w_exp_ext  = req_add ? w_sum_ext : w_dif_ext;

    assign w_used     = UW'(r_s1) + UW'(r_s2) + UW'(r_count);
    assign req_ready  = (w_used < UW'(DEPTH));

    assign w_accept   = req_valid & req_ready;
    assign w_push     = r_s2;
    assign w_pop      = rsp_valid & rsp_ready;
    assign w_mismatch = (unit_result != r_exp2);

    // Operand registers feeding addsub; they keep their value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dataa   <= '0;
            r_datab   <= '0;
            r_add_sub <= 1'b0;
        end else if (w_accept) begin
            r_dataa   <= req_a;
            r_datab   <= req_b;
            r_add_sub <= req_add;
        end
    end

    assign drv_dataa   = r_dataa;
    assign drv_datab   = r_datab;
    assign drv_add_sub = r_add_sub;

    // Shadow pipeline tracking the unit's latency with the locally expected answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= 1'b0;
            r_exp1   <= '0;
            r_carry1 <= 1'b0;
            r_s2     <= 1'b0;
            r_exp2   <= '0;
            r_carry2 <= 1'b0;
        end else begin
            r_s1 <= w_accept;
            if (w_accept) begin
                r_exp1   <= w_exp_ext[WIDTH-1:0];
                r_carry1 <= w_exp_ext[WIDTH];
            end
            r_s2 <= r_s1;
            if (r_s1) begin
                r_exp2   <= r_exp1;
                r_carry2 <= r_carry1;
            end
        end
    end

    // Response FIFO storage; credit accounting guarantees a free slot on every push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i]  <= '0;
                r_mem_carry[i] <= 1'b0;
                r_mem_err[i]   <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr]  <= unit_result;
            r_mem_carry[r_wr_ptr] <= r_carry2;
            r_mem_err[r_wr_ptr]   <= w_mismatch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (w_push && w_mismatch) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;
    assign rsp_valid  = (r_count != '0);
    assign rsp_data   = rsp_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign rsp_carry  = rsp_valid ? r_mem_carry[r_rd_ptr] : 1'b0;
    assign rsp_err    = rsp_valid ? r_mem_err[r_rd_ptr]   : 1'b0;

endmodule
